// File: rtl/out_byte_uart_tx_pkg.sv
// Shared types and constants for the debug-byte UART transmitter.
package out_byte_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/out_byte_uart_tx_fifo.sv
// Single-clock byte FIFO with occupancy count; pushes into a full FIFO are ignored.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/out_byte_uart_tx.sv
// Buffers the CPU debug byte stream and serialises it as 8N1 UART frames on tx.
module out_byte_uart_tx
  import out_byte_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    out_byte,
  input  logic                          out_byte_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             overflow_q, overflow_d;

  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       bit_end;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (out_byte_en),
    .din    (out_byte),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bit_end = (bit_cnt_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | (out_byte_en & fifo_full);

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next-state view so the line changes on the same edge as the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule
